// File: rtl/fs_mem_resp_if.sv
// fs_mem_resp_if: FST memory request/response channels and satp, between walker (master) and responder (slave).
interface fs_mem_resp_if #(
    parameter int MCN_W  = 30,
    parameter int DATA_W = 512,
    parameter int SATP_W = 64
);
    logic              mem_req_o_ready;
    logic              mem_req_o_valid;
    logic [MCN_W-1:0]  mem_req_o_bits_mcn;
    logic              mem_resp_i_ready;
    logic              mem_resp_i_valid;
    logic [DATA_W-1:0] mem_resp_i_bits_data;
    logic [SATP_W-1:0] satp_i;
    modport master (
        input  mem_req_o_ready, mem_resp_i_valid, mem_resp_i_bits_data, satp_i,
        output mem_req_o_valid, mem_req_o_bits_mcn, mem_resp_i_ready
    );
    modport slave (
        output mem_req_o_ready, mem_resp_i_valid, mem_resp_i_bits_data, satp_i,
        input  mem_req_o_valid, mem_req_o_bits_mcn, mem_resp_i_ready
    );
endinterface

// File: rtl/fs_mem_resp.sv
// fs_mem_resp: fixed-latency FST memory responder with preloadable line store and satp register.
// Defining FS_MEM_STALL_EN adds LFSR-driven request backpressure.
module fs_mem_resp #(
    parameter int MCN_W  = 30,
    parameter int IDX_W  = 8,
    parameter int DATA_W = 512,
    parameter int QUEUE  = 4,
    parameter int LAT    = 3,
    parameter int SATP_W = 64
) (
    input  logic               clock,
    input  logic               reset,
    fs_mem_resp_if.slave       bus,
    input  logic               ld_valid,
    input  logic [IDX_W-1:0]   ld_idx,
    input  logic [DATA_W-1:0]  ld_data,
    input  logic               cfg_satp_valid,
    input  logic [SATP_W-1:0]  cfg_satp
);
    localparam int PW = QUEUE > 1 ? $clog2(QUEUE) : 1;
    localparam int CW = $clog2(QUEUE) + 1;

    logic [DATA_W-1:0] store [2**IDX_W];
    logic [DATA_W-1:0] data_q [QUEUE];
    logic [3:0]        cnt_q [QUEUE];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              ready_en, stall, push, pop;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] push_data;

`ifdef FS_MEM_STALL_EN
    logic [15:0] lfsr;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) lfsr <= 16'hACE1;
        else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    assign idx       = bus.mem_req_o_bits_mcn[IDX_W-1:0];
    // Same-cycle store write is forwarded so the accept sees the newest line
    assign push_data = |bus.mem_req_o_bits_mcn[MCN_W-1:IDX_W] ? '0 :
                       (ld_valid && ld_idx == idx) ? ld_data : store[idx];

    assign bus.mem_req_o_ready      = ready_en && count < CW'(QUEUE) && !stall;
    assign bus.mem_resp_i_valid     = count != '0 && cnt_q[rd_ptr] == 4'd0;
    assign bus.mem_resp_i_bits_data = bus.mem_resp_i_valid ? data_q[rd_ptr] : '0;
    assign push = bus.mem_req_o_valid && bus.mem_req_o_ready;
    assign pop  = bus.mem_resp_i_valid && bus.mem_resp_i_ready;

    always_ff @(posedge clock) begin
        if (ld_valid) store[ld_idx] <= ld_data;
        if (push) data_q[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_en   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            bus.satp_i <= '0;
            for (int i = 0; i < QUEUE; i++) cnt_q[i] <= '0;
        end else begin
            ready_en <= 1'b1;
            // Idle slots count down too; a push reloads its slot with LAT
            for (int i = 0; i < QUEUE; i++) cnt_q[i] <= cnt_q[i] == 4'd0 ? 4'd0 : cnt_q[i] - 4'd1;
            if (push) begin
                cnt_q[wr_ptr] <= 4'(LAT);
                wr_ptr        <= wr_ptr == PW'(QUEUE - 1) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr == PW'(QUEUE - 1) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (cfg_satp_valid) bus.satp_i <= cfg_satp;
        end
    end
endmodule

// File: tb/tb_fs_mem_resp.sv
// tb_fs_mem_resp: directed table vectors plus multi-cycle sequences and a scoreboarded random run for fs_mem_resp.
module tb_fs_mem_resp;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ld_valid = 1'b0;
    logic [7:0]   ld_idx = '0;
    logic [511:0] ld_data = '0;
    logic         cfg_satp_valid = 1'b0;
    logic [63:0]  cfg_satp = '0;
    int           errors = 0;
    int           checks = 0;
    logic [511:0] model [16];

    always #5 clk = ~clk;

    fs_mem_resp_if #(.MCN_W(30), .DATA_W(512), .SATP_W(64)) bus ();

    fs_mem_resp dut (
        .clock(clk), .reset(rst_n), .bus(bus),
        .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_data(ld_data),
        .cfg_satp_valid(cfg_satp_valid), .cfg_satp(cfg_satp)
    );

`ifdef FS_MEM_STALL_EN
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_lfsr <= 16'hACE1;
        else m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif

    typedef struct {
        logic         v;
        logic [29:0]  mcn;
        logic         rr;
        logic         e_rdy;
        logic         e_rv;
        logic [511:0] e_d;
    } vec_t;

    function automatic logic [511:0] pat(input int k);
        return k == 5 ? {64{8'hA5}} : k == 7 ? {64{8'h11}} : {16{32'hC0DE_0000 | 32'(k)}};
    endfunction

    function automatic vec_t mk(input logic v, input logic [29:0] mcn, input logic rr,
                                input logic e_rdy, input logic e_rv, input logic [511:0] e_d);
        vec_t t;
        t.v = v; t.mcn = mcn; t.rr = rr; t.e_rdy = e_rdy; t.e_rv = e_rv; t.e_d = e_d;
        return t;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input int k, input logic [511:0] d);
        ld_valid = 1'b1; ld_idx = 8'(k); ld_data = d;
        tick;
        ld_valid = 1'b0;
        model[k] = d;
    endtask

    task automatic wait_resp(input string name, input logic [511:0] exp);
        int n = 0;
        while (!bus.mem_resp_i_valid && n < 10) begin
            tick;
            n++;
        end
        chk({name, "_valid"}, 512'(bus.mem_resp_i_valid), 512'(1));
        if (bus.mem_resp_i_valid) chk(name, bus.mem_resp_i_bits_data, exp);
        tick;
    endtask

    task automatic run_table(input string name, input vec_t tab[$]);
        foreach (tab[i]) begin
            bus.mem_req_o_valid = tab[i].v;
            bus.mem_req_o_bits_mcn = tab[i].mcn;
            bus.mem_resp_i_ready = tab[i].rr;
            chk($sformatf("%s[%0d].ready", name, i), 512'(bus.mem_req_o_ready), 512'(tab[i].e_rdy));
            chk($sformatf("%s[%0d].valid", name, i), 512'(bus.mem_resp_i_valid), 512'(tab[i].e_rv));
            if (tab[i].e_rv) chk($sformatf("%s[%0d].data", name, i), bus.mem_resp_i_bits_data, tab[i].e_d);
            tick;
        end
        bus.mem_req_o_valid = 1'b0;
    endtask

    initial begin
        vec_t tab_a[$];
        vec_t tab_b[$];
        logic [511:0] exp_q[$];
        logic exp_rise;
        logic stale;
        int sent, got, cyc, r;

        bus.mem_req_o_valid = 1'b0;
        bus.mem_req_o_bits_mcn = '0;
        bus.mem_resp_i_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 512'(bus.mem_req_o_ready), '0);
        chk("rst_valid", 512'(bus.mem_resp_i_valid), '0);
        chk("rst_data", bus.mem_resp_i_bits_data, '0);
        chk("rst_satp", 512'(bus.satp_i), '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 512'(bus.mem_req_o_ready), '0);
        tick;
`ifdef FS_MEM_STALL_EN
        exp_rise = !m_lfsr[0];
`else
        exp_rise = 1'b1;
`endif
        chk("ready_rise", 512'(bus.mem_req_o_ready), 512'(exp_rise));

`ifdef FS_MEM_STALL_EN
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("stall_ready[%0d]", i), 512'(bus.mem_req_o_ready), 512'(!m_lfsr[0]));
            tick;
        end
`endif

        for (int k = 0; k < 16; k++) ld(k, pat(k));

`ifndef FS_MEM_STALL_EN
        tab_a.push_back(mk(1, 30'd5,     1, 1, 0, '0));
        tab_a.push_back(mk(1, 30'h100,   1, 1, 0, '0));
        tab_a.push_back(mk(0, 30'd0,     1, 1, 0, '0));
        tab_a.push_back(mk(0, 30'd0,     1, 1, 0, '0));
        tab_a.push_back(mk(0, 30'd0,     1, 1, 1, pat(5)));
        tab_a.push_back(mk(0, 30'd0,     1, 1, 1, '0));
        tab_a.push_back(mk(1, 30'd1,     1, 1, 0, '0));
        tab_a.push_back(mk(1, 30'd2,     1, 1, 0, '0));
        tab_a.push_back(mk(1, 30'd3,     1, 1, 0, '0));
        tab_a.push_back(mk(0, 30'd0,     1, 1, 0, '0));
        tab_a.push_back(mk(0, 30'd0,     1, 1, 1, pat(1)));
        tab_a.push_back(mk(0, 30'd0,     1, 1, 1, pat(2)));
        tab_a.push_back(mk(0, 30'd0,     1, 1, 1, pat(3)));
        tab_a.push_back(mk(0, 30'd0,     1, 1, 0, '0));
        run_table("single", tab_a);

        for (int k = 0; k < 4; k++) tab_b.push_back(mk(1, 30'(k), 0, 1, 0, '0));
        tab_b.push_back(mk(1, 30'd4, 0, 0, 1, pat(0)));
        tab_b.push_back(mk(1, 30'd4, 0, 0, 1, pat(0)));
        tab_b.push_back(mk(1, 30'd4, 1, 0, 1, pat(0)));
        tab_b.push_back(mk(1, 30'd4, 1, 1, 1, pat(1)));
        tab_b.push_back(mk(0, 30'd0, 1, 1, 1, pat(2)));
        tab_b.push_back(mk(0, 30'd0, 1, 1, 1, pat(3)));
        tab_b.push_back(mk(0, 30'd0, 1, 1, 0, '0));
        tab_b.push_back(mk(0, 30'd0, 1, 1, 1, pat(4)));
        tab_b.push_back(mk(0, 30'd0, 1, 1, 0, '0));
        run_table("full", tab_b);

        // Same-cycle store write must be forwarded; later writes must not alter queued data
        bus.mem_resp_i_ready = 1'b1;
        ld_valid = 1'b1; ld_idx = 8'd7; ld_data = {64{8'h77}};
        bus.mem_req_o_valid = 1'b1; bus.mem_req_o_bits_mcn = 30'd7;
        chk("fwd_ready", 512'(bus.mem_req_o_ready), 512'(1));
        tick;
        model[7] = {64{8'h77}};
        ld_valid = 1'b0;
        bus.mem_req_o_bits_mcn = 30'd9;
        tick;
        bus.mem_req_o_valid = 1'b0;
        ld(9, {64{8'h99}});
        wait_resp("fwd_data", {64{8'h77}});
        wait_resp("queued_old", pat(9));
        bus.mem_req_o_valid = 1'b1; bus.mem_req_o_bits_mcn = 30'd9;
        tick;
        bus.mem_req_o_valid = 1'b0;
        wait_resp("store_new", {64{8'h99}});

        cfg_satp_valid = 1'b1; cfg_satp = 64'h8000_0000_1234_5678;
        tick;
        cfg_satp_valid = 1'b0;
        chk("satp_load", 512'(bus.satp_i), 512'(64'h8000_0000_1234_5678));

        bus.mem_resp_i_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            bus.mem_req_o_valid = 1'b1; bus.mem_req_o_bits_mcn = 30'(k);
            tick;
        end
        bus.mem_req_o_valid = 1'b0;
        repeat (2) tick;
        chk("inflight_valid", 512'(bus.mem_resp_i_valid), 512'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 512'(bus.mem_resp_i_valid), '0);
        chk("midrst_satp", 512'(bus.satp_i), '0);
        chk("midrst_ready", 512'(bus.mem_req_o_ready), '0);
        chk("midrst_data", bus.mem_resp_i_bits_data, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_resp_i_ready = 1'b1;
        tick;
        chk("rerise_ready", 512'(bus.mem_req_o_ready), 512'(1));
        stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            stale |= bus.mem_resp_i_valid;
            tick;
        end
        chk("no_stale", 512'(stale), '0);
`endif

        sent = 0; got = 0; cyc = 0;
        while ((sent < 100 || exp_q.size() != 0) && cyc < 5000) begin
            r = $urandom_range(0, 16);
            bus.mem_req_o_valid = sent < 100 && $urandom_range(0, 3) != 0;
            bus.mem_req_o_bits_mcn = r == 16 ? 30'h1F0 : 30'(r);
            bus.mem_resp_i_ready = $urandom_range(0, 3) != 0;
            if (bus.mem_resp_i_valid && bus.mem_resp_i_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_spurious: got response %0h expected none", bus.mem_resp_i_bits_data);
                end else chk($sformatf("rand_data[%0d]", got), bus.mem_resp_i_bits_data, exp_q.pop_front());
                got++;
            end
            if (bus.mem_req_o_valid && bus.mem_req_o_ready) begin
                exp_q.push_back(r == 16 ? '0 : model[r]);
                sent++;
            end
            tick;
            cyc++;
        end
        bus.mem_req_o_valid = 1'b0;
        chk("rand_sent", 512'(sent), 512'(100));
        chk("rand_got", 512'(got), 512'(100));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
